// File: rtl/counter_arb_pkg.sv
// Shared types and defaults for the counter arbiter.
// Build option: COUNTER_ARB_FAIR_EN selects round-robin instead of fixed priority.
package counter_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int WIDTH_DEF   = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational winner selection: request vector (+ rotation pointer) -> one-hot winner.
// COUNTER_ARB_FAIR_EN: search starts at ptr; otherwise lowest index wins.
module rr_pick
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic [NUM_REQ-1:0]         req,
`ifdef COUNTER_ARB_FAIR_EN
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
   output logic [NUM_REQ-1:0]         winner,
   output logic                       valid
);

   localparam int PTR_W = $clog2(NUM_REQ);

`ifdef COUNTER_ARB_FAIR_EN
   always_comb begin
      int v_idx;
      v_idx  = 0;
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_idx = int'(ptr) + i;
         if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
         if (!valid && req[v_idx[PTR_W-1:0]]) begin
            winner[v_idx[PTR_W-1:0]] = 1'b1;
            valid                    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[i[PTR_W-1:0]]) begin
            winner[i[PTR_W-1:0]] = 1'b1;
            valid                = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/counter_arbiter.sv
// Arbiter/sequencer sharing one external up/down step counter between NUM_REQ requesters.
// COUNTER_ARB_FAIR_EN: round-robin grant pointer; undefined: fixed priority, index 0 highest.
//
// state | meaning
// IDLE  | waiting for a request; winner and its opcode latched on exit
// ISSUE | counter enabled for one cycle with the latched opcode
// RESP  | ack to owner, counter value/flag passed through, grant cleared on exit
module counter_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_up,
   input  logic [NUM_REQ-1:0] req_two,
   input  logic [WIDTH-1:0]   ctr_value,
   input  logic               ctr_overflow,
   output logic               ctr_up,
   output logic               ctr_two,
   output logic               ctr_enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] ack,
   output logic [WIDTH-1:0]   resp_value,
   output logic               resp_overflow,
   output logic               busy
);

   localparam int PTR_W = $clog2(NUM_REQ);

   state_t             r_state;
   state_t             w_state_next;
   logic [NUM_REQ-1:0] r_owner;
   logic               r_up;
   logic               r_two;
   logic [NUM_REQ-1:0] w_winner;
   logic               w_valid;
   logic               w_grant;

   assign w_grant = (r_state == IDLE) && w_valid;

`ifdef COUNTER_ARB_FAIR_EN
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_win_idx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .winner (w_winner),
      .valid  (w_valid)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner[i[PTR_W-1:0]]) w_win_idx = i[PTR_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
      end
   end
`else
   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
      .winner (w_winner),
      .valid  (w_valid)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_valid) w_state_next = ISSUE;
         ISSUE:   w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Opcode is captured at grant so later changes on req_up/req_two are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= '0;
         r_up    <= 1'b0;
         r_two   <= 1'b0;
      end else if (w_grant) begin
         r_owner <= w_winner;
         r_up    <= |(req_up & w_winner);
         r_two   <= |(req_two & w_winner);
      end else if (r_state == RESP) begin
         r_owner <= '0;
      end
   end

   // ack is gated by rst so a reset landing in RESP suppresses the pulse that cycle.
   always_comb begin
      ctr_enable    = 1'b0;
      ctr_up        = 1'b0;
      ctr_two       = 1'b0;
      ack           = '0;
      resp_value    = '0;
      resp_overflow = 1'b0;
      case (r_state)
         ISSUE: begin
            ctr_enable = 1'b1;
            ctr_up     = r_up;
            ctr_two    = r_two;
         end
         RESP: begin
            ack           = rst ? '0 : r_owner;
            resp_value    = ctr_value;
            resp_overflow = ctr_overflow;
         end
         default: ;
      endcase
   end

   assign gnt  = r_owner;
   assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural 12-bit step counter attached.
// Expectations switch with COUNTER_ARB_FAIR_EN (round-robin vs fixed priority).
module tb_counter_arbiter;

   localparam int N = 4;
   localparam int W = 12;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] req_up;
   logic [N-1:0] req_two;
   logic [W-1:0] ctr_value;
   logic         ctr_overflow;
   logic         ctr_up;
   logic         ctr_two;
   logic         ctr_enable;
   logic [N-1:0] gnt;
   logic [N-1:0] ack;
   logic [W-1:0] resp_value;
   logic         resp_overflow;
   logic         busy;

   logic         load_en;
   logic [W-1:0] load_val;

   int checks;
   int errors;

   counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_up        (req_up),
      .req_two       (req_two),
      .ctr_value     (ctr_value),
      .ctr_overflow  (ctr_overflow),
      .ctr_up        (ctr_up),
      .ctr_two       (ctr_two),
      .ctr_enable    (ctr_enable),
      .gnt           (gnt),
      .ack           (ack),
      .resp_value    (resp_value),
      .resp_overflow (resp_overflow),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External counter: overflow reports a wrap on the most recent step.
   always @(posedge clk) begin
      logic [W:0] t;
      t = '0;
      if (load_en) begin
         ctr_value    <= load_val;
         ctr_overflow <= 1'b0;
      end else if (ctr_enable) begin
         if (ctr_up) t = {1'b0, ctr_value} + (ctr_two ? 13'd2 : 13'd1);
         else        t = {1'b0, ctr_value} - (ctr_two ? 13'd2 : 13'd1);
         ctr_value    <= t[W-1:0];
         ctr_overflow <= t[W];
      end
   end

   task automatic load_ctr(input logic [W-1:0] v);
      load_val = v;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = '0; req_up = '0; req_two = '0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      checks++; if (ctr_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", ctr_enable); end
      checks++; if (ctr_up !== 1'b0) begin errors++; $display("FAIL reset_up got=%b exp=0", ctr_up); end
      checks++; if (ctr_two !== 1'b0) begin errors++; $display("FAIL reset_two got=%b exp=0", ctr_two); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_single;
      load_ctr(12'h000);
      req = 4'b0010; req_up = 4'b0010; req_two = 4'b0000;
      @(negedge clk);
      checks++; if (ctr_enable !== 1'b1) begin errors++; $display("FAIL single_enable got=%b exp=1", ctr_enable); end
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
      checks++; if ({ctr_up, ctr_two} !== 2'b10) begin errors++; $display("FAIL single_op got=%b exp=10", {ctr_up, ctr_two}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack got=%b exp=0010", ack); end
      checks++; if (resp_value !== 12'h001) begin errors++; $display("FAIL single_value got=%h exp=001", resp_value); end
      checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", resp_overflow); end
      checks++; if (ctr_enable !== 1'b0) begin errors++; $display("FAIL single_enable_once got=%b exp=0", ctr_enable); end
      req = '0;
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_end got=%b exp=0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clr got=%b exp=0000", gnt); end
   endtask

   task automatic test_down_two;
      load_ctr(12'h000);
      req = 4'b1000; req_up = 4'b0000; req_two = 4'b1000;
      @(negedge clk);
      checks++; if ({ctr_enable, ctr_up, ctr_two} !== 3'b101) begin errors++; $display("FAIL down2_op got=%b exp=101", {ctr_enable, ctr_up, ctr_two}); end
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL down2_gnt got=%b exp=1000", gnt); end
      @(negedge clk);
      checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL down2_ack got=%b exp=1000", ack); end
      checks++; if (resp_value !== 12'hFFE) begin errors++; $display("FAIL down2_value got=%h exp=ffe", resp_value); end
      checks++; if (resp_overflow !== 1'b1) begin errors++; $display("FAIL down2_ovf got=%b exp=1", resp_overflow); end
      req = '0; req_two = '0;
      @(negedge clk);
   endtask

   task automatic test_opcode_change;
      load_ctr(12'h010);
      req = 4'b0100; req_up = 4'b0100; req_two = 4'b0100;
      @(negedge clk);
      req = 4'b0000; req_up = 4'b0000; req_two = 4'b0000;
      #1;
      checks++; if ({ctr_enable, ctr_up, ctr_two} !== 3'b111) begin errors++; $display("FAIL opchg_latched got=%b exp=111", {ctr_enable, ctr_up, ctr_two}); end
      @(negedge clk);
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL opchg_ack got=%b exp=0100", ack); end
      checks++; if (resp_value !== 12'h012) begin errors++; $display("FAIL opchg_value got=%h exp=012", resp_value); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL opchg_idle got=%b exp=0", busy); end
   endtask

   task automatic test_all_four;
      int exp_order[5];
      logic [N-1:0] e;
`ifdef COUNTER_ARB_FAIR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load_ctr(12'h000);
      req = 4'b1111; req_up = 4'b1111; req_two = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         e = 4'b0001 << exp_order[k];
         @(negedge clk);
         checks++; if ({ctr_enable, gnt} !== {1'b1, e}) begin errors++; $display("FAIL all4_gnt[%0d] got=%b exp=%b", k, {ctr_enable, gnt}, {1'b1, e}); end
         @(negedge clk);
         checks++; if (ack !== e) begin errors++; $display("FAIL all4_ack[%0d] got=%b exp=%b", k, ack, e); end
         checks++; if (resp_value !== 12'(k + 1)) begin errors++; $display("FAIL all4_value[%0d] got=%h exp=%h", k, resp_value, 12'(k + 1)); end
         if (k == 4) req = '0;
         @(negedge clk);
         checks++; if ({ack, ctr_enable, busy} !== 6'b0) begin errors++; $display("FAIL all4_gap[%0d] got=%b exp=000000", k, {ack, ctr_enable, busy}); end
      end
   endtask

   task automatic test_rst_issue;
      load_ctr(12'h100);
      req = 4'b0100; req_up = 4'b0100; req_two = 4'b0000;
      @(negedge clk);
      checks++; if ({ctr_enable, gnt} !== 5'b1_0100) begin errors++; $display("FAIL rstiss_gnt got=%b exp=10100", {ctr_enable, gnt}); end
      rst = 1'b1; req = '0;
      @(negedge clk);
      checks++; if ({busy, ack, gnt} !== 9'b0) begin errors++; $display("FAIL rstiss_idle got=%b exp=000000000", {busy, ack, gnt}); end
      checks++; if (ctr_value !== 12'h101) begin errors++; $display("FAIL rstiss_counter got=%h exp=101", ctr_value); end
      rst = 1'b0;
      req = 4'b1101; req_up = 4'b1101; req_two = 4'b0000;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstiss_ptr got=%b exp=0001", gnt); end
      @(negedge clk);
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rstiss_ack got=%b exp=0001", ack); end
      checks++; if (resp_value !== 12'h102) begin errors++; $display("FAIL rstiss_value got=%h exp=102", resp_value); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_rst_resp;
      req = 4'b0010; req_up = 4'b0000; req_two = 4'b0000;
      @(negedge clk);
      checks++; if (ctr_enable !== 1'b1) begin errors++; $display("FAIL rstresp_enable got=%b exp=1", ctr_enable); end
      @(negedge clk);
      rst = 1'b1; req = '0;
      #1;
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rstresp_ack got=%b exp=0000", ack); end
      @(negedge clk);
      checks++; if ({busy, ack} !== 5'b0) begin errors++; $display("FAIL rstresp_idle got=%b exp=00000", {busy, ack}); end
      rst = 1'b0;
   endtask

   task automatic test_priority;
      int exp_order[3];
      logic [N-1:0] e;
`ifdef COUNTER_ARB_FAIR_EN
      exp_order = '{0, 2, 0};
`else
      exp_order = '{0, 0, 0};
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0101; req_up = 4'b0101; req_two = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         e = 4'b0001 << exp_order[k];
         @(negedge clk);
         checks++; if (gnt !== e) begin errors++; $display("FAIL prio_gnt[%0d] got=%b exp=%b", k, gnt, e); end
         @(negedge clk);
         checks++; if (ack !== e) begin errors++; $display("FAIL prio_ack[%0d] got=%b exp=%b", k, ack, e); end
         if (k == 2) req = '0;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      req      = '0;
      req_up   = '0;
      req_two  = '0;
      load_en  = 1'b1;
      load_val = '0;
      test_reset();
      load_en  = 1'b0;
      test_single();
      test_down_two();
      test_opcode_change();
      test_all_four();
      test_rst_issue();
      test_rst_resp();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one 12-bit up/down step counter between `NUM_REQ` requesters. Each requester asks for one step operation (±1 or ±2). The arbiter grants one requester at a time, drives the counter's `up`/`two`/`enable` controls for exactly one cycle, then returns the post-update counter value and overflow flag with a one-cycle `ack`. It sits between the requesting control blocks and the counter instance; the counter itself stays outside this block.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 12, counter value width

Ports:
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `req` input NUM_REQ: per-requester request, held high until its `ack`
- `req_up` input NUM_REQ: per-requester direction, 1 = increment
- `req_two` input NUM_REQ: per-requester step size, 1 = step 2, 0 = step 1
- `ctr_value` input WIDTH: current counter register value
- `ctr_overflow` input 1: current counter overflow flag
- `ctr_up` output 1: to counter `up`
- `ctr_two` output 1: to counter `two`
- `ctr_enable` output 1: to counter `enable`
- `gnt` output NUM_REQ: one-hot owner of the current operation
- `ack` output NUM_REQ: one-cycle completion pulse to the owner
- `resp_value` output WIDTH: counter value after the granted step
- `resp_overflow` output 1: overflow flag after the granted step
- `busy` output 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `req` is high, select the winner, latch its `req_up`/`req_two` into the opcode registers, set `gnt` one-hot, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `ctr_enable`=1, `ctr_up`/`ctr_two` = latched opcode. The counter updates at the end of this cycle. Next state is RESP.
- RESP: `ack[owner]`=1, `resp_value`=`ctr_value`, `resp_overflow`=`ctr_overflow` (combinational pass-through of the updated counter). Clear `gnt`. Next state is IDLE.
- Winner selection is round-robin:
  - Search starts at pointer `ptr`; the first `req` high at index `ptr`, `ptr+1`, … (mod NUM_REQ) wins.
  - After a grant, `ptr` ← winner+1 mod NUM_REQ.
- Opcodes are latched at grant. Changes to `req_up`/`req_two`, or dropping `req`, after the grant are ignored; the operation still completes and `ack` still pulses.
- A requester that keeps `req` high after `ack` is re-eligible from the next IDLE cycle.
- Counter wrap-around and overflow are the counter's business. The arbiter only forwards the flag; it never saturates or modifies the value.
- `ctr_enable` is high in ISSUE only. `ack` is high in RESP only. At most one `ack` bit is high.

## Timing
- Reset values: state IDLE, `ptr`=0, `gnt`=0, `ack`=0, `ctr_enable`=0, `ctr_up`=0, `ctr_two`=0, `busy`=0. `resp_value`/`resp_overflow` are don't-care outside RESP and driven to 0 there.
- Latency: `req` rises in cycle T (state IDLE) → `gnt` visible T+1 (ISSUE, `ctr_enable`) → `ack` in T+2.
- Throughput: one operation per 3 cycles under continuous requests.
- `rst` asserted in ISSUE: the counter still sees `ctr_enable` for that cycle; the arbiter returns to IDLE with no `ack`.
- `rst` asserted in RESP: no `ack` is issued from that cycle on.
- Simultaneous `req` from all requesters: grants go `ptr`, `ptr+1`, … with no requester granted twice before the others.

## Configuration
- `COUNTER_ARB_FAIR_EN` defined: round-robin selection with `ptr` as described.
- Not defined: fixed priority, lowest index wins. The `ptr` register is removed, and requester 0 can starve others.

## Structure
- Shared package `counter_arb_pkg`: FSM state enum (IDLE/ISSUE/RESP) and the `NUM_REQ`/`WIDTH` default constants.
- One sub-module, `rr_pick`: combinational winner selection (request vector + `ptr` → one-hot winner + valid). Under fixed priority it reduces to a priority encoder.

## Test plan
- Reset then single request: `req[1]`=1, `req_up[1]`=1, `req_two[1]`=0, `ctr_value` 0 → `ctr_enable` high for exactly one cycle, `ack[1]` at T+2, `resp_value`=1.
- All four requesting continuously, fair build → grant order 0,1,2,3,0 with `ack` spaced every 3 cycles.
- Down-by-2 from 0: `req_up`=0, `req_two`=1 → `resp_value`=12'hFFE, `resp_overflow` = counter flag (1).
- Opcode change after grant: flip `req_up` in ISSUE → counter receives the latched opcode; `ack` still pulses.
- `rst` in ISSUE → no `ack`, state IDLE next cycle, `ptr`=0.
- Fixed-priority build, `req[0]` and `req[2]` held high → only requester 0 is granted.
